imu_bias_cal: RTL and testbench
===============================

Name: imu_bias_cal

Overview:
Gyro bias calibration and correction stage between the MPU SPI driver and the attitude-processing FSM (CORDIC/Kalman/UART).
- After reset, or on request, averages 2^CAL_SAMPLES_LOG2 stationary gyro samples to estimate per-axis bias.
- Thereafter emits bias-corrected gyro plus pass-through accel, with a one-cycle valid pulse per sample.
- Downstream FSM consumes out_valid in place of the raw driver valid.

Parameters:
CAL_SAMPLES_LOG2, 6, log2 of samples averaged per calibration window (6 gives 64 samples); legal range 1..8.
MOTION_THRESH, 200, max allowed |gyro - first-window-sample| per axis, in raw LSB, before the window is discarded.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  one-cycle pulse: new sample on in_* buses
in_accel_x/y/z  in  16 each  signed raw accel
in_gyro_x/y/z  in  16 each  signed raw gyro
recal  in  1  one-cycle pulse: restart calibration
out_valid  out  1  one-cycle pulse: corrected sample on out_* buses
out_accel_x/y/z  out  16 each  signed accel, registered pass-through
out_gyro_x/y/z  out  16 each  signed gyro minus bias, saturated
bias_x/y/z  out  16 each  signed current bias estimate
calibrated  out  1  high while in S_RUN
cal_restarts  out  8  count of windows discarded for motion, saturates at 255

Behaviour:
- Single clock domain. Interface fixed: one clock (clk); reset rst_n is synchronous and active-low.
- All state updates on posedge clk.
- Reset (rst_n low at posedge):
  - state=S_CAL; all out_* = 0; bias_* = 0; out_valid=0; calibrated=0; cal_restarts=0.
  - Accumulators=0; sample count=0; reference regs=0.
- States: S_CAL, S_RUN.
- S_CAL:
  - out_valid held 0.
  - On in_valid with count==0: store gyro as reference; acc_* = gyro (sign-extended to 16+CAL_SAMPLES_LOG2 bits); count=1.
  - On in_valid with count>0:
    - If any axis |gyro - ref| > MOTION_THRESH (17-bit difference, strict compare): clear acc/count, cal_restarts+1 (saturating). Sample is not accumulated and does not start a new window; the next sample becomes the reference.
    - Otherwise: acc += gyro; count+1.
  - When the accumulated sample makes count reach 2^CAL_SAMPLES_LOG2, in the same edge:
    - bias_* = acc_final >>> CAL_SAMPLES_LOG2 (arithmetic, floor toward -inf).
    - State becomes S_RUN; calibrated=1.
    - That sample is not output.
- S_RUN:
  - On in_valid, the next edge registers:
    - out_gyro_* = sat16(in_gyro_* - bias_*), computed in 17 bits and clamped to [-32768, 32767].
    - out_accel_* = in_accel_*.
    - out_valid=1 for exactly one cycle.
  - Latency is 1 cycle.
  - out_* buses hold their values between pulses.
- recal:
  - In S_RUN: recal takes priority over a simultaneous in_valid; that sample is dropped.
    - Next state S_CAL; calibrated=0; acc/count cleared.
    - bias_* retained until the new window completes.
    - out_valid=0 on that edge.
  - In S_CAL: clears acc/count and restarts the window; a simultaneous in_valid is ignored. cal_restarts is not incremented.
- Back-to-back in_valid on consecutive cycles is supported in both states with no throughput loss.
- Reset mid-window or mid-run returns to the full reset state at the next edge.

Optional Feature:
IMU_BIAS_DEADBAND_EN:
- When defined, in S_RUN each corrected gyro axis with |value| <= 3 LSB is output as 0, after saturation.
- When undefined, corrected values pass unmodified.
- Calibration behaviour is identical in both builds.

Test Plan:
1. Bias estimate (CAL_SAMPLES_LOG2=2):
   - Stimulus: reset, then 4 samples gyro_x = 10, 12, 11, 9; y = -5 each; z = 0.
   - Required: calibrated=1 after the 4th; bias_x=10 (42>>>2), bias_y=-5, bias_z=0; no out_valid during calibration.
2. Correction and latency:
   - Stimulus: after test 1, in_valid with gyro=(110,-5,3), accel=(100,-200,16384).
   - Required: one cycle later out_valid=1 for one cycle, out_gyro=(100,0,3), out_accel=(100,-200,16384).
3. Motion rejection (MOTION_THRESH=200):
   - Stimulus: calibration samples gyro_x = 0, 50, 300.
   - Required: window discarded at 300; cal_restarts=1; calibrated stays 0. Four further samples of 8 then give bias_x=8.
4. Saturation:
   - Stimulus: bias_x=-100, in gyro_x=32700.
   - Required: out_gyro_x=32767. With bias_x=100, in gyro_x=-32700: out_gyro_x=-32768.
5. Recal priority:
   - Stimulus: in S_RUN, recal and in_valid in the same cycle.
   - Required: no out_valid; calibrated=0 next cycle; bias unchanged until 4 new samples, after which it updates.
6. Deadband (macro defined):
   - Stimulus: bias=0, gyro=(3,-3,4).
   - Required: out_gyro=(0,0,4). Without the macro: (3,-3,4).

Source files
------------

// File: rtl/imu_bias_cal.sv
// Gyro bias calibration and correction: averages a stationary window to estimate
// per-axis bias, then emits bias-corrected gyro. Optional macro: IMU_BIAS_DEADBAND_EN.
module imu_bias_cal #(
    parameter int CAL_SAMPLES_LOG2 = 6,
    parameter int MOTION_THRESH    = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic signed [15:0] in_accel_x,
    input  logic signed [15:0] in_accel_y,
    input  logic signed [15:0] in_accel_z,
    input  logic signed [15:0] in_gyro_x,
    input  logic signed [15:0] in_gyro_y,
    input  logic signed [15:0] in_gyro_z,
    input  logic               recal,
    output logic               out_valid,
    output logic signed [15:0] out_accel_x,
    output logic signed [15:0] out_accel_y,
    output logic signed [15:0] out_accel_z,
    output logic signed [15:0] out_gyro_x,
    output logic signed [15:0] out_gyro_y,
    output logic signed [15:0] out_gyro_z,
    output logic signed [15:0] bias_x,
    output logic signed [15:0] bias_y,
    output logic signed [15:0] bias_z,
    output logic               calibrated,
    output logic [7:0]         cal_restarts
);

    localparam int AW = 16 + CAL_SAMPLES_LOG2;
    localparam int CW = CAL_SAMPLES_LOG2 + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << CAL_SAMPLES_LOG2) - 1);
    localparam logic [16:0] THRESH = 17'(MOTION_THRESH);

    typedef enum logic {
        S_CAL = 1'b0,
        S_RUN = 1'b1
    } state_t;

    state_t             state_q;
    logic               out_valid_q;
    logic               calibrated_q;
    logic [7:0]         restarts_q;
    logic [CW-1:0]      count_q;
    logic signed [15:0] gyro_in     [3];
    logic signed [15:0] accel_in    [3];
    logic signed [15:0] ref_q       [3];
    logic signed [15:0] bias_q      [3];
    logic signed [AW-1:0] acc_q     [3];
    logic signed [15:0] out_gyro_q  [3];
    logic signed [15:0] out_accel_q [3];

    logic signed [AW-1:0] acc_sum_d [3];
    logic signed [15:0]   bias_d    [3];
    logic [16:0]          diff_d    [3];
    logic [16:0]          mag_d     [3];
    logic [16:0]          corr17_d  [3];
    logic signed [15:0]   sat_d     [3];
    logic signed [15:0]   corr_d    [3];
    logic [2:0]           motion_d;

    assign gyro_in[0]  = in_gyro_x;
    assign gyro_in[1]  = in_gyro_y;
    assign gyro_in[2]  = in_gyro_z;
    assign accel_in[0] = in_accel_x;
    assign accel_in[1] = in_accel_y;
    assign accel_in[2] = in_accel_z;

    always_comb begin
        motion_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            acc_sum_d[i] = acc_q[i] + $signed({{CAL_SAMPLES_LOG2{gyro_in[i][15]}}, gyro_in[i]});
            bias_d[i]    = 16'(acc_sum_d[i] >>> CAL_SAMPLES_LOG2);
            // Motion check against the window's first sample, in 17 bits so it cannot wrap.
            diff_d[i]    = {gyro_in[i][15], gyro_in[i]} - {ref_q[i][15], ref_q[i]};
            mag_d[i]     = diff_d[i][16] ? (17'd0 - diff_d[i]) : diff_d[i];
            motion_d[i]  = (mag_d[i] > THRESH);
            corr17_d[i]  = {gyro_in[i][15], gyro_in[i]} - {bias_q[i][15], bias_q[i]};
            if (corr17_d[i][16:15] == 2'b01) begin
                sat_d[i] = 16'sh7FFF;
            end else if (corr17_d[i][16:15] == 2'b10) begin
                sat_d[i] = 16'sh8000;
            end else begin
                sat_d[i] = $signed(corr17_d[i][15:0]);
            end
`ifdef IMU_BIAS_DEADBAND_EN
            if ((sat_d[i] >= -16'sd3) && (sat_d[i] <= 16'sd3)) begin
                corr_d[i] = 16'sd0;
            end else begin
                corr_d[i] = sat_d[i];
            end
`else
            corr_d[i] = sat_d[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_CAL;
            out_valid_q  <= 1'b0;
            calibrated_q <= 1'b0;
            restarts_q   <= 8'd0;
            count_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                ref_q[i]       <= '0;
                bias_q[i]      <= '0;
                acc_q[i]       <= '0;
                out_gyro_q[i]  <= '0;
                out_accel_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_CAL: begin
                    if (recal) begin
                        count_q <= '0;
                        for (int i = 0; i < 3; i++) acc_q[i] <= '0;
                    end else if (in_valid) begin
                        if (count_q == '0) begin
                            count_q <= CW'(1);
                            for (int i = 0; i < 3; i++) begin
                                ref_q[i] <= gyro_in[i];
                                acc_q[i] <= $signed({{CAL_SAMPLES_LOG2{gyro_in[i][15]}}, gyro_in[i]});
                            end
                        end else if (motion_d != 3'b000) begin
                            // Discard the window; the next sample becomes the new reference.
                            count_q <= '0;
                            for (int i = 0; i < 3; i++) acc_q[i] <= '0;
                            if (restarts_q != 8'hFF) restarts_q <= restarts_q + 8'd1;
                        end else if (count_q == LAST_CNT) begin
                            state_q      <= S_RUN;
                            calibrated_q <= 1'b1;
                            count_q      <= '0;
                            for (int i = 0; i < 3; i++) begin
                                bias_q[i] <= bias_d[i];
                                acc_q[i]  <= '0;
                            end
                        end else begin
                            count_q <= count_q + CW'(1);
                            for (int i = 0; i < 3; i++) acc_q[i] <= acc_sum_d[i];
                        end
                    end
                end
                S_RUN: begin
                    // recal wins over a coincident sample; the old bias stays until the new window lands.
                    if (recal) begin
                        state_q      <= S_CAL;
                        calibrated_q <= 1'b0;
                        count_q      <= '0;
                        for (int i = 0; i < 3; i++) acc_q[i] <= '0;
                    end else if (in_valid) begin
                        out_valid_q <= 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            out_gyro_q[i]  <= corr_d[i];
                            out_accel_q[i] <= accel_in[i];
                        end
                    end
                end
                default: state_q <= S_CAL;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign calibrated   = calibrated_q;
    assign cal_restarts = restarts_q;
    assign out_gyro_x   = out_gyro_q[0];
    assign out_gyro_y   = out_gyro_q[1];
    assign out_gyro_z   = out_gyro_q[2];
    assign out_accel_x  = out_accel_q[0];
    assign out_accel_y  = out_accel_q[1];
    assign out_accel_z  = out_accel_q[2];
    assign bias_x       = bias_q[0];
    assign bias_y       = bias_q[1];
    assign bias_z       = bias_q[2];

endmodule

// File: tb/tb_imu_bias_cal.sv
// Directed bench for imu_bias_cal with a 4-sample window: vector table for
// correction plus hand sequences for calibration, motion, recal and saturation.
module tb_imu_bias_cal;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] in_accel_x, in_accel_y, in_accel_z;
    logic signed [15:0] in_gyro_x, in_gyro_y, in_gyro_z;
    logic               recal;
    logic               out_valid;
    logic signed [15:0] out_accel_x, out_accel_y, out_accel_z;
    logic signed [15:0] out_gyro_x, out_gyro_y, out_gyro_z;
    logic signed [15:0] bias_x, bias_y, bias_z;
    logic               calibrated;
    logic [7:0]         cal_restarts;

    int n_tests;
    int n_fail;

    typedef struct {
        int gx, gy, gz;
        int ax, ay, az;
        int ex, ey, ez;
    } vec_t;

    vec_t tbl[4];

    imu_bias_cal #(
        .CAL_SAMPLES_LOG2(2),
        .MOTION_THRESH(200)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_accel_x(in_accel_x),
        .in_accel_y(in_accel_y),
        .in_accel_z(in_accel_z),
        .in_gyro_x(in_gyro_x),
        .in_gyro_y(in_gyro_y),
        .in_gyro_z(in_gyro_z),
        .recal(recal),
        .out_valid(out_valid),
        .out_accel_x(out_accel_x),
        .out_accel_y(out_accel_y),
        .out_accel_z(out_accel_z),
        .out_gyro_x(out_gyro_x),
        .out_gyro_y(out_gyro_y),
        .out_gyro_z(out_gyro_z),
        .bias_x(bias_x),
        .bias_y(bias_y),
        .bias_z(bias_z),
        .calibrated(calibrated),
        .cal_restarts(cal_restarts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int db(input int v);
`ifdef IMU_BIAS_DEADBAND_EN
        if (v >= -3 && v <= 3) return 0;
`endif
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the edge that consumed them.
    task automatic step(input logic v, input logic rc, input int gx, input int gy, input int gz,
                        input int ax, input int ay, input int az);
        in_valid   = v;
        recal      = rc;
        in_gyro_x  = 16'(gx);
        in_gyro_y  = 16'(gy);
        in_gyro_z  = 16'(gz);
        in_accel_x = 16'(ax);
        in_accel_y = 16'(ay);
        in_accel_z = 16'(az);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        recal    = 1'b0;
    endtask

    task automatic sample(input int gx, input int gy, input int gz);
        step(1'b1, 1'b0, gx, gy, gz, 0, 0, 0);
    endtask

    task automatic do_recal();
        step(1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cal4(input int gx, input int gy, input int gz);
        for (int i = 0; i < 4; i++) sample(gx, gy, gz);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        recal    = 1'b0;
        tbl[0] = '{gx: 110,    gy: -5,    gz: 3,    ax: 100,   ay: -200, az: 16384,  ex: 100,    ey: 0,     ez: 3};
        tbl[1] = '{gx: -32768, gy: 32767, gz: 0,    ax: -1,    ay: 1,    az: -32768, ex: -32768, ey: 32767, ez: 0};
        tbl[2] = '{gx: 0,      gy: 0,     gz: 0,    ax: 7,     ay: 8,    az: 9,      ex: -10,    ey: 5,     ez: 0};
        tbl[3] = '{gx: 5,      gy: -3,    gz: -100, ax: 32767, ay: 0,    az: 0,      ex: -5,     ey: 2,     ez: -100};

        // Reset state
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 77, 77, 77, 5, 5, 5);
        check("rst_valid", out_valid, 0);
        check("rst_cal", calibrated, 0);
        check("rst_bias_x", bias_x, 0);
        check("rst_restarts", cal_restarts, 0);
        check("rst_out_gx", out_gyro_x, 0);
        check("rst_out_az", out_accel_z, 0);
        rst_n = 1'b1;

        // Bias estimate
        sample(10, -5, 0);
        check("cal1_valid", out_valid, 0);
        sample(12, -5, 0);
        sample(11, -5, 0);
        check("cal3_cal", calibrated, 0);
        check("cal3_valid", out_valid, 0);
        sample(9, -5, 0);
        check("cal4_cal", calibrated, 1);
        check("cal4_valid", out_valid, 0);
        check("bias_x", bias_x, 10);
        check("bias_y", bias_y, -5);
        check("bias_z", bias_z, 0);

        // Correction vectors, back to back
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, tbl[i].gx, tbl[i].gy, tbl[i].gz, tbl[i].ax, tbl[i].ay, tbl[i].az);
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_gx", i), out_gyro_x, db(tbl[i].ex));
            check($sformatf("vec%0d_gy", i), out_gyro_y, db(tbl[i].ey));
            check($sformatf("vec%0d_gz", i), out_gyro_z, db(tbl[i].ez));
            check($sformatf("vec%0d_ax", i), out_accel_x, tbl[i].ax);
            check($sformatf("vec%0d_ay", i), out_accel_y, tbl[i].ay);
            check($sformatf("vec%0d_az", i), out_accel_z, tbl[i].az);
        end
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        check("idle_valid", out_valid, 0);
        check("hold_gx", out_gyro_x, db(-5));
        check("hold_ax", out_accel_x, 32767);

        // Recal priority in S_RUN, then recal restart in S_CAL
        step(1'b1, 1'b1, 500, 500, 500, 1, 1, 1);
        check("rp_valid", out_valid, 0);
        check("rp_cal", calibrated, 0);
        check("rp_bias_x", bias_x, 10);
        check("rp_hold_gx", out_gyro_x, db(-5));
        sample(20, 20, 20);
        sample(20, 20, 20);
        step(1'b1, 1'b1, 5000, 5000, 5000, 0, 0, 0);
        check("rc_restarts", cal_restarts, 0);
        sample(20, 20, 20);
        sample(20, 20, 20);
        check("rc_cal_still0", calibrated, 0);
        check("rc_bias_kept", bias_x, 10);
        sample(20, 20, 20);
        sample(20, 20, 20);
        check("rc_cal", calibrated, 1);
        check("rc_bias_x", bias_x, 20);
        check("rc_bias_y", bias_y, 20);

        // Motion rejection
        do_recal();
        sample(0, 0, 0);
        sample(50, 0, 0);
        sample(300, 0, 0);
        check("mot_restarts", cal_restarts, 1);
        check("mot_cal", calibrated, 0);
        sample(8, 0, 0);
        sample(8, 0, 0);
        sample(8, 0, 0);
        check("mot_cal3", calibrated, 0);
        sample(8, 0, 0);
        check("mot_cal4", calibrated, 1);
        check("mot_bias_x", bias_x, 8);

        // Threshold is strict: a difference of exactly 200 is accepted
        do_recal();
        sample(0, 0, 0);
        sample(200, 0, 0);
        sample(-200, 0, 0);
        sample(0, 0, 0);
        check("thr_cal", calibrated, 1);
        check("thr_restarts", cal_restarts, 1);
        check("thr_bias_x", bias_x, 0);

        // Deadband around zero with zero bias
        step(1'b1, 1'b0, 3, -3, 4, 0, 0, 0);
        check("db_gx", out_gyro_x, db(3));
        check("db_gy", out_gyro_y, db(-3));
        check("db_gz", out_gyro_z, 4);

        // Saturation
        do_recal();
        cal4(-100, 0, 0);
        check("satp_bias", bias_x, -100);
        step(1'b1, 1'b0, 32700, 0, 0, 0, 0, 0);
        check("satp_gx", out_gyro_x, 32767);
        do_recal();
        cal4(100, 0, 0);
        check("satn_bias", bias_x, 100);
        step(1'b1, 1'b0, -32700, 0, 0, 0, 0, 0);
        check("satn_gx", out_gyro_x, -32768);

        // Reset mid-run
        rst_n = 1'b0;
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        check("mrst_cal", calibrated, 0);
        check("mrst_bias", bias_x, 0);
        check("mrst_restarts", cal_restarts, 0);
        check("mrst_gx", out_gyro_x, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
